// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

   // One buffered fetch result handed to decode.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a flush input.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  if_entry_t                  din,
   output if_entry_t                  dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   if_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pointer/count update; clear wins over any push or pop in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push & ~clear & (~full | pop);
      do_pop   = pop & ~clear & ~empty;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: sequential fetch issue with credit-limited
// outstanding requests, in-order response buffering and redirect flushing.
module instr_fetch #(
   parameter int unsigned      AW         = 12,
   parameter int unsigned      XLEN       = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC   = fetch_pkg::RESET_PC_DEF,
   parameter int unsigned      FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   output logic                instr_req,
   output logic                instr_write,
   output logic [XLEN/8-1:0]   instr_wstrb,
   output logic [AW-1:0]       instr_addr,
   output logic [XLEN-1:0]     instr_wdata,
   input  logic                instr_addr_ok,
   input  logic                instr_data_ok,
   input  logic [XLEN-1:0]     instr_rdata,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                if_valid,
   input  logic                if_ready,
   output logic [XLEN-1:0]     if_pc,
   output logic [XLEN-1:0]     if_instr
);

   import fetch_pkg::*;

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic              started_q, started_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     discard_q, discard_d;

   logic [CW-1:0]     fifo_cnt;
   logic              fifo_empty, fifo_full;
   if_entry_t         fifo_din, fifo_head;
   logic [CW+1:0]     credits_used;
   logic              accept, drop, push, pop;
   logic [XLEN-1:0]   redir_pc;

   assign instr_write = 1'b0;
   assign instr_wstrb = '0;
   assign instr_wdata = '0;
   assign instr_addr  = fetch_pc_q[AW+1:2];
   assign if_valid    = ~fifo_empty;
   assign if_pc       = fifo_head.pc;
   assign if_instr    = fifo_head.instr;

   // Issue and response classification; every issued request owns a FIFO slot.
   always_comb begin
      credits_used = {2'b00, fifo_cnt} + {2'b00, inflight_q} + {2'b00, discard_q};
      instr_req    = started_q & ~redirect_valid & (credits_used < (CW+2)'(FIFO_DEPTH));
      accept       = instr_req & instr_addr_ok;
      drop         = instr_data_ok & (discard_q != '0);
      push         = instr_data_ok & ~drop;
      pop          = ~fifo_empty & if_ready;
      redir_pc     = redirect_pc & ~XLEN'(3);
      fifo_din     = '{pc: resp_pc_q, instr: instr_rdata};
   end

   // PC and credit bookkeeping; a redirect turns all in-flight requests stale.
   always_comb begin
      started_d  = 1'b1;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
         resp_pc_d  = redir_pc;
         discard_d  = discard_q + inflight_q - CW'(instr_data_ok);
         inflight_d = '0;
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (push)   resp_pc_d  = resp_pc_q + XLEN'(4);
         if (drop)   discard_d  = discard_q - CW'(1);
         inflight_d = inflight_q + CW'(accept) - CW'(push);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started_q  <= 1'b0;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         started_q  <= started_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_head),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // The credit scheme must never let a push land on a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && fifo_full && !redirect_valid));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a RAM model with random accept/return
// timing drives the DUT while a stream-level scoreboard predicts decode output.
module tb_instr_fetch;

   localparam int unsigned AW    = 12;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [XLEN-1:0] RST_PC = 32'h0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              instr_req, instr_write;
   logic [XLEN/8-1:0] instr_wstrb;
   logic [AW-1:0]     instr_addr;
   logic [XLEN-1:0]   instr_wdata;
   logic              instr_addr_ok = 1'b0;
   logic              instr_data_ok = 1'b0;
   logic [XLEN-1:0]   instr_rdata = '0;
   logic              redirect_valid = 1'b0;
   logic [XLEN-1:0]   redirect_pc = '0;
   logic              if_valid;
   logic              if_ready = 1'b0;
   logic [XLEN-1:0]   if_pc, if_instr;

   always #5 clk = ~clk;

   instr_fetch #(
      .AW         (AW),
      .XLEN       (XLEN),
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req      (instr_req),
      .instr_write    (instr_write),
      .instr_wstrb    (instr_wstrb),
      .instr_addr     (instr_addr),
      .instr_wdata    (instr_wdata),
      .instr_addr_ok  (instr_addr_ok),
      .instr_data_ok  (instr_data_ok),
      .instr_rdata    (instr_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   // RAM contents
   logic [XLEN-1:0] mem [1 << AW];

   // In-flight RAM request: stream epoch it belongs to, predicted PC, data the RAM returns
   typedef struct {
      int unsigned     epoch;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } ram_req_t;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } dec_entry_t;

   ram_req_t    ramq[$];
   dec_entry_t  expq[$];
   int unsigned epoch;
   logic [XLEN-1:0] fetch_pc_m;
   bit          started_m;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Stimulus rates in percent
   int unsigned p_ready, p_addr_ok, p_data_ok, p_redir;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] pick_target();
      logic [XLEN-1:0] t;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFE0 | XLEN'($urandom_range(0, 31));
      else                           t = XLEN'($urandom_range(0, 1023));
      return t;
   endfunction

   // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
   task automatic step();
      bit              exp_req, accept, ret, do_pop;
      logic [AW-1:0]   ram_addr;
      logic [XLEN-1:0] exp_addr_pc;
      ram_req_t        e;
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      redirect_pc    = pick_target();
      if_ready       = ($urandom_range(0, 99) < p_ready);
      instr_addr_ok  = ($urandom_range(0, 99) < p_addr_ok);
      if (ramq.size() > 0 && $urandom_range(0, 99) < p_data_ok) begin
         instr_data_ok = 1'b1;
         instr_rdata   = ramq[0].data;
      end else begin
         instr_data_ok = 1'b0;
         instr_rdata   = $urandom;
      end
      @(negedge clk);
      exp_req = started_m && !redirect_valid && (expq.size() + ramq.size() < DEPTH);
      check("instr_req", 64'(instr_req), 64'(exp_req));
      check("if_valid", 64'(if_valid), 64'(expq.size() > 0));
      if (expq.size() > 0) begin
         check("if_pc", 64'(if_pc), 64'(expq[0].pc));
         check("if_instr", 64'(if_instr), 64'(expq[0].instr));
      end
      exp_addr_pc = fetch_pc_m;
      if (exp_req) check("instr_addr", 64'(instr_addr), 64'(exp_addr_pc[AW+1:2]));
      accept   = exp_req && instr_addr_ok;
      ram_addr = instr_addr;
      do_pop   = !redirect_valid && expq.size() > 0 && if_ready;
      @(posedge clk);
      ret = 1'b0;
      if (instr_data_ok) begin
         e = ramq.pop_front();
         ret = !redirect_valid && (e.epoch == epoch);
      end
      if (do_pop) void'(expq.pop_front());
      if (ret) expq.push_back('{pc: e.pc, instr: mem[e.pc[AW+1:2]]});
      if (redirect_valid) begin
         expq.delete();
         epoch++;
         fetch_pc_m = redirect_pc & ~32'h3;
      end else if (accept) begin
         ramq.push_back('{epoch: epoch, pc: fetch_pc_m, data: mem[ram_addr]});
         fetch_pc_m = fetch_pc_m + 32'd4;
      end
      started_m = 1'b1;
      #1;
   endtask

   // Asynchronous reset mid-cycle; RAM drops its pending responses.
   task automatic do_reset();
      #2;
      rst            = 1'b1;
      instr_data_ok  = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("rst_instr_req", 64'(instr_req), 64'(0));
      check("rst_if_valid", 64'(if_valid), 64'(0));
      check("rst_instr_write", 64'(instr_write), 64'(0));
      check("rst_instr_wstrb", 64'(instr_wstrb), 64'(0));
      check("rst_instr_wdata", 64'(instr_wdata), 64'(0));
      ramq.delete();
      expq.delete();
      epoch++;
      fetch_pc_m = RST_PC;
      started_m  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   initial begin
      bit setup_ok;
      for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      epoch      = 0;
      fetch_pc_m = RST_PC;
      started_m  = 1'b0;

      // Power-on reset
      #2;
      check("por_instr_req", 64'(instr_req), 64'(0));
      check("por_if_valid", 64'(if_valid), 64'(0));
      check("por_instr_write", 64'(instr_write), 64'(0));
      check("por_instr_wstrb", 64'(instr_wstrb), 64'(0));
      check("por_instr_wdata", 64'(instr_wdata), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Ideal RAM and decode: back-to-back streaming from RESET_PC
      p_ready = 100; p_addr_ok = 100; p_data_ok = 100; p_redir = 0;
      run(30);

      // Decode stalls: FIFO fills, issue stops, then drains and resumes
      p_ready = 0;
      run(15);
      p_ready = 100;
      run(15);

      // Random traffic with redirects
      p_ready = 70; p_addr_ok = 80; p_data_ok = 100; p_redir = 6;
      run(1500);
      p_ready = 60; p_addr_ok = 70; p_data_ok = 60; p_redir = 10;
      run(1500);

      // Reset with entries buffered and a request in flight
      p_ready = 0; p_addr_ok = 100; p_data_ok = 50; p_redir = 0;
      setup_ok = 1'b0;
      for (int unsigned i = 0; i < 60 && !setup_ok; i++) begin
         step();
         setup_ok = (expq.size() >= 2) && (ramq.size() >= 1);
      end
      check("rst_setup_reached", 64'(setup_ok), 64'(1));
      do_reset();
      p_ready = 100; p_addr_ok = 100; p_data_ok = 100; p_redir = 0;
      run(20);
      p_ready = 70; p_addr_ok = 80; p_data_ok = 70; p_redir = 8;
      run(1500);

      check("final_instr_write", 64'(instr_write), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
